code_tx: RTL and testbench



---
 rtl/code_tx.sv | 165 ++++++++++++++++
 tb/tb_code_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_tx.sv
// UART 8N1 transmitter for the 80-bit processor result: sends bytes MSB-first,
// optionally skipping zero bytes and appending an end-of-line byte.
module code_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter bit          SKIP_ZERO    = 1'b1,
  parameter bit          SEND_EOL     = 1'b1,
  parameter logic [7:0]  EOL          = 8'h0A
) (
  input  logic        msclk,
  input  logic        rst,
  input  logic [79:0] code,
  input  logic        flag,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        drop,
  output logic [3:0]  byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  IDX_EOL  = 4'd10;
  localparam logic [3:0]  IDX_FIN  = 4'd11;

  state_t      state_q;
  logic [79:0] cap_q;
  logic [3:0]  idx_q;
  logic [15:0] timer_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        drop_q;
  logic [3:0]  cnt_q;

  logic [7:0]  code_byte [10];
  logic [7:0]  sel_byte;
  logic        code_phase;
  logic        eol_phase;
  logic        bit_end;
  logic        skip_byte;

  // Byte 0 is the most significant byte of the captured word.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_bytes
      assign code_byte[gi] = cap_q[79-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    sel_byte   = 8'h00;
    code_phase = (idx_q <= 4'd9);
    if (code_phase) begin
      sel_byte = code_byte[idx_q];
    end
    eol_phase = SEND_EOL && (idx_q == IDX_EOL);
    skip_byte = SKIP_ZERO && (sel_byte == 8'h00);
    bit_end   = (timer_q == BIT_LAST);
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      drop_q <= flag && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (flag) begin
            cap_q   <= code;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          timer_q <= '0;
          bit_q   <= '0;
          if (code_phase) begin
            idx_q <= idx_q + 4'd1;
            if (!skip_byte) begin
              shift_q <= sel_byte;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end else if (eol_phase) begin
            // Index 11 records that the terminator has been issued.
            idx_q   <= IDX_FIN;
            shift_q <= EOL;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          if (bit_end) begin
            timer_q <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer_q <= '0;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            timer_q <= '0;
            cnt_q   <= cnt_q + 4'd1;
            state_q <= S_NEXT;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign drop     = drop_q;
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_code_tx.sv
// Bench for code_tx: two instances (with and without EOL) checked against a
// frame/timeline model computed from the byte list of each word.
module tb_code_tx;

  localparam int C = 4;
  localparam logic [79:0] HELLO = 80'h48454C4C4F0000000000;

  logic        msclk = 1'b0;
  logic        rst;
  logic [79:0] code_a, code_b;
  logic        flag_a, flag_b;
  logic        tx_a, busy_a, done_a, drop_a;
  logic        tx_b, busy_b, done_b, drop_b;
  logic [3:0]  cnt_a, cnt_b;

  code_tx #(.CLKS_PER_BIT(C), .SKIP_ZERO(1'b1), .SEND_EOL(1'b1), .EOL(8'h0A)) dut_a (
    .msclk(msclk), .rst(rst), .code(code_a), .flag(flag_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .drop(drop_a), .byte_cnt(cnt_a)
  );

  code_tx #(.CLKS_PER_BIT(C), .SKIP_ZERO(1'b1), .SEND_EOL(1'b0), .EOL(8'h0A)) dut_b (
    .msclk(msclk), .rst(rst), .code(code_b), .flag(flag_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .drop(drop_b), .byte_cnt(cnt_b)
  );

  always #5 msclk = ~msclk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic       tr[$];
  string      obs_frames;
  int         obs_done, obs_drops, obs_ferr;
  logic [3:0] obs_cnt;
  logic       obs_busy0, obs_busy_end, obs_done_after;

  // Model: walk the bytes in send order on a cycle timeline starting at E0+1.
  function automatic string model_frames(input logic [79:0] c, input bit eol,
                                         output int done_at, output int nframes);
    string s;
    int t;
    logic [7:0] b;
    s = "";
    t = 1;
    nframes = 0;
    for (int i = 0; i < 10; i++) begin
      b = 8'(c >> (72 - 8*i));
      if (b == 8'h00) begin
        t += 1;
      end else begin
        s = {s, $sformatf("%02x@%0d ", b, t)};
        t += 10*C + 1;
        nframes++;
      end
    end
    if (eol) begin
      s = {s, $sformatf("0a@%0d ", t)};
      t += 10*C + 1;
      nframes++;
    end
    done_at = t;
    return s;
  endfunction

  // Sends one word and records tx per cycle (index j = after edge E0+j), then decodes frames.
  task automatic run_transfer(input bit sel, input logic [79:0] c, input int drop_at, input string name);
    int p;
    logic [7:0] b;
    logic v;
    if (sel) begin code_b = c; flag_b = 1'b1; end
    else begin code_a = c; flag_a = 1'b1; end
    @(negedge msclk);
    flag_a = 1'b0;
    flag_b = 1'b0;
    code_a = {16'($urandom), $urandom, $urandom};
    code_b = {16'($urandom), $urandom, $urandom};
    tr.delete();
    obs_done = -1; obs_drops = 0; obs_ferr = 0; obs_frames = "";
    obs_cnt = 4'hx; obs_busy_end = 1'bx;
    for (int j = 0; j < 3000; j++) begin
      if (j == 0) obs_busy0 = sel ? busy_b : busy_a;
      if (sel ? drop_b : drop_a) obs_drops++;
      if (sel ? done_b : done_a) begin
        obs_done = j;
        obs_busy_end = sel ? busy_b : busy_a;
        obs_cnt = sel ? cnt_b : cnt_a;
        break;
      end
      tr.push_back(sel ? tx_b : tx_a);
      if (j == drop_at) begin
        if (sel) flag_b = 1'b1; else flag_a = 1'b1;
      end else begin
        flag_a = 1'b0;
        flag_b = 1'b0;
      end
      @(negedge msclk);
    end
    flag_a = 1'b0;
    flag_b = 1'b0;
    @(negedge msclk);
    obs_done_after = sel ? done_b : done_a;
    p = 0;
    while (p < tr.size()) begin
      if (tr[p] === 1'b0) begin
        if (p + 10*C > tr.size()) begin
          obs_ferr++;
          break;
        end
        b = 8'h00;
        for (int k = 0; k < 10; k++) begin
          v = tr[p + C*k];
          for (int m = 1; m < C; m++) if (tr[p + C*k + m] !== v) obs_ferr++;
          if (k == 0 && v !== 1'b0) obs_ferr++;
          if (k == 9 && v !== 1'b1) obs_ferr++;
          if (k >= 1 && k <= 8) b[k-1] = v;
        end
        obs_frames = {obs_frames, $sformatf("%02x@%0d ", b, p)};
        p += 10*C;
      end else begin
        if (tr[p] !== 1'b1) obs_ferr++;
        p++;
      end
    end
    $display("xfer %s: code=%020x frames=[%s] done@%0d cnt=%0d drops=%0d", name, c, obs_frames,
             obs_done, obs_cnt, obs_drops);
  endtask

  task automatic test_reset();
    int lows;
    rst = 1'b1;
    flag_a = 1'b0; flag_b = 1'b0;
    code_a = '0; code_b = '0;
    repeat (3) @(negedge msclk);
    rst = 1'b0;
    @(negedge msclk);
    cmp_cnt++; if (tx_a !== 1'b1) begin err_cnt++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    cmp_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    cmp_cnt++; if (done_a !== 1'b0) begin err_cnt++; $display("FAIL reset_done got=%b exp=0", done_a); end
    cmp_cnt++; if (drop_a !== 1'b0) begin err_cnt++; $display("FAIL reset_drop got=%b exp=0", drop_a); end
    cmp_cnt++; if (cnt_a !== 4'd0) begin err_cnt++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
    lows = 0;
    for (int j = 0; j < 100; j++) begin
      if (tx_a !== 1'b1 || tx_b !== 1'b1) lows++;
      @(negedge msclk);
    end
    cmp_cnt++; if (lows != 0) begin err_cnt++; $display("FAIL reset_idle_tx got=%0d non-idle cycles exp=0", lows); end
    $display("xfer reset: idle check over 100 cycles, non-idle=%0d", lows);
  endtask

  task automatic test_hello();
    string ef;
    int ed, en;
    logic [0:7] seq;
    logic [0:7] exp_seq;
    exp_seq = 8'b0001_0010;
    ef = model_frames(HELLO, 1'b1, ed, en);
    run_transfer(1'b0, HELLO, -1, "hello");
    for (int k = 0; k < 8; k++) seq[k] = (tr.size() > 1 + C*(1+k)) ? tr[1 + C*(1+k)] : 1'bx;
    cmp_cnt++; if (obs_frames != ef) begin err_cnt++; $display("FAIL hello_frames got=[%s] exp=[%s]", obs_frames, ef); end
    cmp_cnt++; if (seq !== exp_seq) begin err_cnt++; $display("FAIL hello_bit_order got=%b exp=%b", seq, exp_seq); end
    cmp_cnt++; if (obs_done != 252) begin err_cnt++; $display("FAIL hello_done got=%0d exp=252", obs_done); end
    cmp_cnt++; if (obs_cnt !== 4'd6) begin err_cnt++; $display("FAIL hello_cnt got=%0d exp=6", obs_cnt); end
    cmp_cnt++; if (obs_busy0 !== 1'b1) begin err_cnt++; $display("FAIL hello_busy_start got=%b exp=1", obs_busy0); end
    cmp_cnt++; if (obs_busy_end !== 1'b0) begin err_cnt++; $display("FAIL hello_busy_end got=%b exp=0", obs_busy_end); end
    cmp_cnt++; if (obs_done_after !== 1'b0) begin err_cnt++; $display("FAIL hello_done_width got=%b exp=0", obs_done_after); end
    cmp_cnt++; if (obs_ferr != 0) begin err_cnt++; $display("FAIL hello_framing got=%0d exp=0", obs_ferr); end
  endtask

  task automatic test_zero_skip();
    string ef;
    int ed, en;
    ef = model_frames(80'h41004200000000000000, 1'b0, ed, en);
    run_transfer(1'b1, 80'h41004200000000000000, -1, "zero_skip");
    cmp_cnt++; if (obs_frames != "41@1 42@43 ") begin err_cnt++; $display("FAIL skip_frames got=[%s] exp=[41@1 42@43 ]", obs_frames); end
    cmp_cnt++; if (obs_frames != ef) begin err_cnt++; $display("FAIL skip_model got=[%s] exp=[%s]", obs_frames, ef); end
    cmp_cnt++; if (obs_done != 91) begin err_cnt++; $display("FAIL skip_done got=%0d exp=91", obs_done); end
    cmp_cnt++; if (obs_cnt !== 4'd2) begin err_cnt++; $display("FAIL skip_cnt got=%0d exp=2", obs_cnt); end
    cmp_cnt++; if (obs_ferr != 0) begin err_cnt++; $display("FAIL skip_framing got=%0d exp=0", obs_ferr); end
  endtask

  task automatic test_all_zero();
    run_transfer(1'b1, 80'h0, -1, "all_zero");
    cmp_cnt++; if (obs_frames != "") begin err_cnt++; $display("FAIL zero_frames got=[%s] exp=[]", obs_frames); end
    cmp_cnt++; if (obs_done != 11) begin err_cnt++; $display("FAIL zero_done got=%0d exp=11", obs_done); end
    cmp_cnt++; if (obs_cnt !== 4'd0) begin err_cnt++; $display("FAIL zero_cnt got=%0d exp=0", obs_cnt); end
    cmp_cnt++; if (obs_ferr != 0) begin err_cnt++; $display("FAIL zero_tx_idle got=%0d exp=0", obs_ferr); end
  endtask

  task automatic test_overrun();
    string ef;
    int ed, en;
    ef = model_frames(HELLO, 1'b1, ed, en);
    run_transfer(1'b0, HELLO, 60, "overrun");
    cmp_cnt++; if (obs_drops != 1) begin err_cnt++; $display("FAIL overrun_drop got=%0d exp=1", obs_drops); end
    cmp_cnt++; if (obs_frames != ef) begin err_cnt++; $display("FAIL overrun_frames got=[%s] exp=[%s]", obs_frames, ef); end
    cmp_cnt++; if (obs_done != ed) begin err_cnt++; $display("FAIL overrun_done got=%0d exp=%0d", obs_done, ed); end
    cmp_cnt++; if (obs_cnt !== 4'(en)) begin err_cnt++; $display("FAIL overrun_cnt got=%0d exp=%0d", obs_cnt, en); end
  endtask

  task automatic test_reset_mid();
    string ef;
    int ed, en, dones;
    code_a = HELLO;
    flag_a = 1'b1;
    @(negedge msclk);
    flag_a = 1'b0;
    repeat (6) @(negedge msclk);
    cmp_cnt++; if (tx_a !== 1'b0) begin err_cnt++; $display("FAIL rstmid_pre_tx got=%b exp=0", tx_a); end
    #2 rst = 1'b1;
    #1;
    cmp_cnt++; if (tx_a !== 1'b1) begin err_cnt++; $display("FAIL rstmid_tx got=%b exp=1", tx_a); end
    cmp_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    @(negedge msclk);
    @(negedge msclk);
    rst = 1'b0;
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      if (done_a !== 1'b0) dones++;
      @(negedge msclk);
    end
    cmp_cnt++; if (dones != 0) begin err_cnt++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
    $display("xfer reset_mid: abandoned frame, done pulses=%0d", dones);
    ef = model_frames(HELLO, 1'b1, ed, en);
    run_transfer(1'b0, HELLO, -1, "after_reset");
    cmp_cnt++; if (obs_frames != ef) begin err_cnt++; $display("FAIL rstmid_frames got=[%s] exp=[%s]", obs_frames, ef); end
    cmp_cnt++; if (obs_done != ed) begin err_cnt++; $display("FAIL rstmid_done got=%0d exp=%0d", obs_done, ed); end
  endtask

  task automatic test_random();
    logic [79:0] c;
    logic [7:0] b;
    bit sel;
    int drop_at, ed, en;
    string ef;
    for (int it = 0; it < 8; it++) begin
      c = '0;
      for (int k = 0; k < 10; k++) begin
        b = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        c = {c[71:0], b};
      end
      sel = it[0];
      ef = model_frames(c, !sel, ed, en);
      drop_at = (it % 3 == 0) ? -1 : int'($urandom_range(0, ed - 1));
      run_transfer(sel, c, drop_at, $sformatf("random%0d", it));
      cmp_cnt++; if (obs_frames != ef) begin err_cnt++; $display("FAIL rand%0d_frames got=[%s] exp=[%s]", it, obs_frames, ef); end
      cmp_cnt++; if (obs_done != ed) begin err_cnt++; $display("FAIL rand%0d_done got=%0d exp=%0d", it, obs_done, ed); end
      cmp_cnt++; if (obs_cnt !== 4'(en)) begin err_cnt++; $display("FAIL rand%0d_cnt got=%0d exp=%0d", it, obs_cnt, en); end
      cmp_cnt++; if (obs_drops != ((drop_at >= 0) ? 1 : 0)) begin err_cnt++; $display("FAIL rand%0d_drop got=%0d exp=%0d", it, obs_drops, (drop_at >= 0) ? 1 : 0); end
      cmp_cnt++; if (obs_ferr != 0) begin err_cnt++; $display("FAIL rand%0d_framing got=%0d exp=0", it, obs_ferr); end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_zero_skip();
    test_all_zero();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
